// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller: scan-byte constants,
// parser state encoding and the packed key-event layout {ext, brk, code}.
package ps2_kbd_pkg;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;
   localparam logic [7:0] BYTE_AA = 8'hAA;
   localparam logic [7:0] BYTE_FA = 8'hFA;
   localparam logic [7:0] BYTE_EE = 8'hEE;
   localparam logic [7:0] BYTE_FE = 8'hFE;
   localparam logic [7:0] BYTE_00 = 8'h00;
   localparam logic [7:0] BYTE_FF = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE_E0,
      ST_PRE_F0,
      ST_PRE_E0F0,
      ST_PAUSE
   } parser_state_t;

   localparam int unsigned EVT_W        = 10;
   localparam int unsigned EVT_EXT_POS  = 9;
   localparam int unsigned EVT_BRK_POS  = 8;
   localparam int unsigned EVT_CODE_LSB = 0;

   // Bytes that follow E1 in the Pause make sequence
   localparam logic [2:0] PAUSE_BYTES = 3'd7;

   function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic brk,
                                                 input logic [7:0] code);
      return {ext, brk, code};
   endfunction

   function automatic logic is_overrun(input logic [7:0] b);
      return (b == BYTE_00) || (b == BYTE_FF);
   endfunction

   function automatic logic is_protocol(input logic [7:0] b);
      return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_EE) || (b == BYTE_FE);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous show-ahead FIFO. rdata presents the head entry whenever
// empty is low and reads zero when empty. A push while full is accepted only
// if a pop happens in the same cycle.
module ps2_evt_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer, count and storage next-state
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are masked by empty so no reset is needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: gates the byte receiver, parses scan bytes into
// make/break, normal/extended key events and queues them in a show-ahead FIFO.
// Optional macro PS2_SHIFT_TRACK_EN adds the shift_state output.
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_en,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       err_tick,
   output logic       ovf_flag,
   input  logic       clr_ovf
`ifdef PS2_SHIFT_TRACK_EN
   ,
   output logic       shift_state
`endif
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

   parser_state_t     state_q, state_d;
   logic [2:0]        pause_q, pause_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_tick_q, err_tick_d;
   logic              rx_en_q, rx_en_d;
   logic              ovf_q, ovf_d;
   logic              evt_push;
   logic [EVT_W-1:0]  evt_data;
   logic [EVT_W-1:0]  head;
   logic              fifo_empty, fifo_full;
   logic [CW-1:0]     fifo_count;
   logic              pop;

   assign key_valid = !fifo_empty;
   assign pop       = key_valid && key_ready;
   assign key_code  = head[EVT_CODE_LSB +: 8];
   assign key_ext   = head[EVT_EXT_POS];
   assign key_break = head[EVT_BRK_POS];
   assign err_tick  = err_tick_q;
   assign rx_en     = rx_en_q;
   assign ovf_flag  = ovf_q;

   ps2_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (evt_push),
      .wdata (evt_data),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Parser next-state, event push and sequence timeout
   always_comb begin
      state_d    = state_q;
      pause_d    = pause_q;
      tmo_d      = tmo_q;
      err_tick_d = 1'b0;
      evt_push   = 1'b0;
      evt_data   = pack_evt(1'b0, 1'b0, rx_data);
      if (rx_done_tick) begin
         tmo_d = '0;
         unique case (state_q)
            ST_IDLE: begin
               if (rx_data == BYTE_E0) begin
                  state_d = ST_PRE_E0;
               end else if (rx_data == BYTE_F0) begin
                  state_d = ST_PRE_F0;
               end else if (rx_data == BYTE_E1) begin
                  state_d = ST_PAUSE;
                  pause_d = PAUSE_BYTES;
               end else if (is_overrun(rx_data)) begin
                  err_tick_d = 1'b1;
               end else if (!is_protocol(rx_data)) begin
                  evt_push = 1'b1;
               end
            end
            ST_PRE_E0: begin
               state_d = ST_IDLE;
               if (rx_data == BYTE_F0) begin
                  state_d = ST_PRE_E0F0;
               end else if (is_overrun(rx_data)) begin
                  err_tick_d = 1'b1;
               end else begin
                  evt_push = 1'b1;
                  evt_data = pack_evt(1'b1, 1'b0, rx_data);
               end
            end
            ST_PRE_F0: begin
               state_d = ST_IDLE;
               if (is_overrun(rx_data)) begin
                  err_tick_d = 1'b1;
               end else begin
                  evt_push = 1'b1;
                  evt_data = pack_evt(1'b0, 1'b1, rx_data);
               end
            end
            ST_PRE_E0F0: begin
               state_d = ST_IDLE;
               if (is_overrun(rx_data)) begin
                  err_tick_d = 1'b1;
               end else begin
                  evt_push = 1'b1;
                  evt_data = pack_evt(1'b1, 1'b1, rx_data);
               end
            end
            ST_PAUSE: begin
               if (is_overrun(rx_data)) begin
                  err_tick_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  pause_d = pause_q - 3'd1;
                  if (pause_q == 3'd1) begin
                     evt_push = 1'b1;
                     evt_data = pack_evt(1'b0, 1'b0, BYTE_E1);
                     state_d  = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q == ST_IDLE) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         tmo_d      = '0;
         state_d    = ST_IDLE;
         err_tick_d = 1'b1;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Receive gating and sticky overflow next-state
   always_comb begin
      rx_en_d = (fifo_count < CW'(FIFO_DEPTH - 1));
      ovf_d   = ovf_q;
      if (evt_push && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Controller registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pause_q    <= '0;
         tmo_q      <= '0;
         err_tick_q <= 1'b0;
         rx_en_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pause_q    <= pause_d;
         tmo_q      <= tmo_d;
         err_tick_q <= err_tick_d;
         rx_en_q    <= rx_en_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef PS2_SHIFT_TRACK_EN
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;

   logic lshift_q, lshift_d;
   logic rshift_q, rshift_d;

   assign shift_state = lshift_q || rshift_q;

   // Shift flags track every parsed event, including ones dropped on overflow
   always_comb begin
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      if (evt_push && !evt_data[EVT_EXT_POS]) begin
         if (evt_data[EVT_CODE_LSB +: 8] == CODE_LSHIFT) begin
            lshift_d = !evt_data[EVT_BRK_POS];
         end
         if (evt_data[EVT_CODE_LSB +: 8] == CODE_RSHIFT) begin
            rshift_d = !evt_data[EVT_BRK_POS];
         end
      end
   end

   // Shift flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
      end else begin
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_ps2_kbd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       err_tick;
   logic       ovf_flag;
   logic       clr_ovf;
`ifdef PS2_SHIFT_TRACK_EN
   logic       shift_state;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (40)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rx_en        (rx_en),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_break    (key_break),
      .err_tick     (err_tick),
      .ovf_flag     (ovf_flag),
      .clr_ovf      (clr_ovf)
`ifdef PS2_SHIFT_TRACK_EN
      ,
      .shift_state  (shift_state)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One-cycle rx_done_tick; returns at the falling edge of the following cycle
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   // Check head event {ext,brk,code} then pop it
   task automatic pop_chk(input string tag, input logic [9:0] exp);
      chk({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
      chk({tag, "_evt"}, {22'd0, key_ext, key_break, key_code}, {22'd0, exp});
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   task automatic count_err(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (err_tick) n++;
      end
   endtask

   initial begin
      int ne;
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      key_ready    = 1'b0;
      clr_ovf      = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_rx_en", {31'd0, rx_en}, 32'd0);
      chk("rst_valid", {31'd0, key_valid}, 32'd0);
      chk("rst_evt", {22'd0, key_ext, key_break, key_code}, 32'd0);
      chk("rst_err", {31'd0, err_tick}, 32'd0);
      chk("rst_ovf", {31'd0, ovf_flag}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rx_en_after_rst", {31'd0, rx_en}, 32'd1);

      // Plain make, then break; valid exactly one cycle after final byte
      send(8'h1C);
      pop_chk("make_1c", 10'h01C);
      chk("empty_after_pop", {31'd0, key_valid}, 32'd0);
      send(8'hF0);
      chk("f0_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'h1C);
      pop_chk("brk_1c", 10'h11C);

      // Extended make/break with protocol bytes in between
      send(8'hE0);
      chk("e0_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'h75);
      pop_chk("ext_make_75", 10'h275);
      send(8'hAA);
      send(8'hFA);
      @(negedge clk);
      chk("proto_ignored", {31'd0, key_valid}, 32'd0);
      send(8'hE0);
      send(8'hF0);
      chk("e0f0_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'h75);
      pop_chk("ext_brk_75", 10'h375);

      // Truncated E0 sequence times out after 40 idle cycles
      send(8'hE0);
      count_err(30, ne);
      chk("tmo_early", ne, 32'd0);
      count_err(40, ne);
      chk("tmo_err_once", ne, 32'd1);
      chk("tmo_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'h1C);
      pop_chk("after_tmo_1c", 10'h01C);

      // Fill the FIFO with the consumer stalled
      send(8'h15);
      send(8'h1D);
      chk("rx_en_cnt2", {31'd0, rx_en}, 32'd1);
      send(8'h24);
      @(negedge clk);
      chk("rx_en_cnt3", {31'd0, rx_en}, 32'd0);
      send(8'h2D);
      chk("ovf_before", {31'd0, ovf_flag}, 32'd0);
      send(8'h2C);
      chk("ovf_set", {31'd0, ovf_flag}, 32'd1);
      pop_chk("fifo0", 10'h015);
      pop_chk("fifo1", 10'h01D);
      pop_chk("fifo2", 10'h024);
      pop_chk("fifo3", 10'h02D);
      chk("fifo_drained", {31'd0, key_valid}, 32'd0);
      chk("ovf_sticky", {31'd0, ovf_flag}, 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("ovf_clr", {31'd0, ovf_flag}, 32'd0);
      chk("rx_en_back", {31'd0, rx_en}, 32'd1);

      // Pause sequence produces a single E1 event
      send(8'hE1);
      send(8'h14);
      send(8'h77);
      send(8'hE1);
      send(8'hF0);
      send(8'h14);
      send(8'hF0);
      chk("pause_partial", {31'd0, key_valid}, 32'd0);
      send(8'h77);
      pop_chk("pause_e1", 10'h0E1);
      chk("pause_single", {31'd0, key_valid}, 32'd0);

      // Overrun byte in IDLE and after F0
      send(8'h00);
      chk("ovr00_err", {31'd0, err_tick}, 32'd1);
      @(negedge clk);
      chk("ovr00_err_pulse", {31'd0, err_tick}, 32'd0);
      chk("ovr00_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'hF0);
      send(8'hFF);
      chk("f0ff_err", {31'd0, err_tick}, 32'd1);
      chk("f0ff_no_evt", {31'd0, key_valid}, 32'd0);
      send(8'h1C);
      pop_chk("after_ff_1c", 10'h01C);

`ifdef PS2_SHIFT_TRACK_EN
      chk("shift_init", {31'd0, shift_state}, 32'd0);
      send(8'h12);
      chk("shift_l", {31'd0, shift_state}, 32'd1);
      send(8'h59);
      send(8'hF0);
      send(8'h12);
      chk("shift_r_held", {31'd0, shift_state}, 32'd1);
      send(8'hF0);
      send(8'h59);
      chk("shift_released", {31'd0, shift_state}, 32'd0);
      pop_chk("sh0", 10'h012);
      pop_chk("sh1", 10'h059);
      pop_chk("sh2", 10'h112);
      pop_chk("sh3", 10'h159);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Controller between the PS/2 byte receiver and the keyboard consumer logic. It gates the receiver's rx_en and parses the received byte stream into make/break, normal/extended key events. It discards protocol bytes, recovers from truncated sequences with a timeout, and queues events in a small FIFO with a valid/ready output handshake.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one multi-byte sequence (1 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_done_tick  in  1  one-cycle pulse from receiver: rx_data valid
rx_data  in  8  received scan byte
rx_en  out  1  receive enable to receiver
key_valid  out  1  FIFO head event available
key_ready  in  1  consumer accepts head event
key_code  out  8  head event scan code
key_ext  out  1  head event had E0 prefix
key_break  out  1  head event is release (F0)
err_tick  out  1  one-cycle pulse: sequence aborted (timeout or 00/FF overrun byte)
ovf_flag  out  1  sticky: an event was dropped because FIFO full
clr_ovf  in  1  clears ovf_flag

Behaviour:
- One clock domain; all state updates on posedge clk; reset synchronous, active-high.
- Reset: parser state IDLE, FIFO empty, timeout counter 0, pause counter 0, rx_en=0, key_valid=0, err_tick=0, ovf_flag=0. key_code/key_ext/key_break read 0.
- rx_en is registered. Its next value is 1 when FIFO count < FIFO_DEPTH-1, so one slot is reserved for a byte already in flight. It is 1 in the first cycle after reset deasserts.
- Parser states: IDLE, PRE_E0, PRE_F0, PRE_E0F0, PAUSE. Transitions happen only on rx_done_tick.
- IDLE: E0->PRE_E0; F0->PRE_F0; E1->PAUSE with pause counter=7; AA/FA/EE/FE ignored; 00/FF -> err_tick; any other byte pushes {ext=0,brk=0,code}.
- PRE_E0: F0->PRE_E0F0; 00/FF -> err_tick and go to IDLE; otherwise push {1,0,code} and go to IDLE.
- PRE_F0: 00/FF -> err_tick and go to IDLE; otherwise push {0,1,code} and go to IDLE.
- PRE_E0F0: 00/FF -> err_tick and go to IDLE; otherwise push {1,1,code} and go to IDLE.
- PAUSE: each byte decrements the pause counter. When the counter reaches 0, push {0,0,E1} and go to IDLE. 00/FF -> err_tick and go to IDLE.
- Timeout counter: cleared on every rx_done_tick and while in IDLE; increments otherwise. At TIMEOUT_CYCLES-1 it forces IDLE and pulses err_tick; the partial sequence is dropped with no push.
- Latency: rx_done_tick in cycle N carrying the final byte -> key_valid high in cycle N+1 (FIFO previously empty).
- FIFO is show-ahead: key_* show the head entry whenever key_valid=1. A pop occurs when key_valid & key_ready. key_ready while empty has no effect.
- Push while full with no pop in the same cycle: the event is dropped and ovf_flag is set. Push and pop in the same cycle while full: both take effect and count is unchanged.
- ovf_flag: set has priority over clr_ovf in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is width clog2(FIFO_DEPTH)+1.
- Reset mid-sequence or with a non-empty FIFO discards everything.

Optional Feature:
Macro PS2_SHIFT_TRACK_EN.
- Defined: adds output shift_state (1 bit). It is set on a make event of 12 or 59 (non-ext) and cleared when both left and right shift are released. It uses two internal flags updated at push time, including pushes dropped by overflow. Reset value is 0.
- Undefined: no port and no flags.

Decomposition:
- Package ps2_kbd_pkg holds:
  - byte constants E0, F0, E1, AA, FA, EE, FE, 00, FF;
  - the parser state enum encoding;
  - the event width constant (10) and field offsets {ext, brk, code}.
- Sub-module ps2_evt_fifo: generic synchronous show-ahead FIFO (width, depth) with full, count and empty outputs. The parser stays in ps2_kbd_ctrl.

Test Plan:
- Bytes 1C, then F0 1C -> events {0,0,1C} then {0,1,1C}; key_valid rises exactly 1 cycle after each final rx_done_tick.
- E0 75, then E0 F0 75 -> events {1,0,75} then {1,1,75}; AA and FA between them produce no event.
- E0 followed by silence for TIMEOUT_CYCLES -> err_tick pulses once, state IDLE; a later 1C yields {0,0,1C} with ext=0.
- key_ready=0 with 5 make codes sent, FIFO_DEPTH=4 -> rx_en falls after count reaches 3; 4 events held; 5th dropped; ovf_flag=1. Pulse clr_ovf -> ovf_flag=0.
- E1 14 77 E1 F0 14 F0 77 -> single event {0,0,E1}; then 00 -> err_tick pulses and no event is produced.
- With PS2_SHIFT_TRACK_EN: 12, 59, F0 12 -> shift_state stays 1; F0 59 -> 0.
